// File: rtl/urisc_pkg.sv
// Shared definitions for the integer issue path: register count, register index
// type and the issue controller state encoding.
package urisc_pkg;

  localparam int NUM_REGS = 8;

  typedef logic [2:0] reg_idx_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } ix_state_e;

endpackage : urisc_pkg

// File: rtl/ix_hazard_ctrl_pending_ctr.sv
// pending_ctr: one saturating up/down count of in-flight writes to a register,
// with a sticky flag for a retire that arrives when nothing is outstanding.
module pending_ctr #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_underflow;
  logic             w_underflow_evt;

  // Next count and underflow event from this cycle's issue and retire.
  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_underflow_evt = 1'b0;
    case ({i_inc, i_dec})
      2'b10: begin
        if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      2'b01: begin
        if (r_cnt != CNT_ZERO) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else begin
          w_underflow_evt = 1'b1;
        end
      end
      2'b11: begin
        // Issue and retire cancel; a retire against an empty count is still an error.
        if (r_cnt == CNT_ZERO) begin
          w_underflow_evt = 1'b1;
        end else begin
          w_underflow_evt = 1'b0;
        end
      end
      default: begin
        w_cnt_nxt = r_cnt;
      end
    endcase
  end

  // Count register and sticky underflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= CNT_ZERO;
      r_underflow <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_underflow <= r_underflow | w_underflow_evt;
    end
  end

  assign o_cnt       = r_cnt;
  assign o_underflow = r_underflow;

endmodule : pending_ctr

// File: rtl/ix_hazard_ctrl.sv
// ix_hazard_ctrl: RAW/WAW issue gate in front of execute with a flush drain state.
// Optional stall watchdog built only when HAZARD_TIMEOUT_EN is defined.
module ix_hazard_ctrl #(
  parameter int NUM_REGS      = urisc_pkg::NUM_REGS,
  parameter int CNT_W         = 2,
  parameter int STALL_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid_idix_p1,
  input  logic [2:0]          rs_idix_p1,
  input  logic [2:0]          rt_idix_p1,
  input  logic [2:0]          rd_idix_p1,
  input  logic [2:0]          src_use_idix_p1,
  input  logic [2:0]          dest_reg_idix_p1,
  input  logic                reg_write_valid_idix_p1,
  input  logic [2:0]          dest_reg_index_memwb_p1,
  input  logic                dest_reg_write_valid_memwb_p1,
  input  logic                flush_p1,
  output logic                issue_grant_p1,
  output logic                stall_idix_p1,
  output logic [NUM_REGS-1:0] pending_mask_p1,
  output logic                underflow_err_p1,
  output logic                hazard_timeout_p1
);

  import urisc_pkg::ix_state_e;
  import urisc_pkg::RUN;
  import urisc_pkg::DRAIN;
  import urisc_pkg::reg_idx_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ix_state_e           r_state;
  ix_state_e           w_state_nxt;
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic [NUM_REGS-1:0] w_uflow;
  logic [NUM_REGS-1:0] w_pending;
  logic [CNT_W-1:0]    w_cnt [NUM_REGS];
  logic                w_raw;
  logic                w_sat;
  logic                w_haz;
  logic                w_grant;
  logic                w_stall;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_ctr
    assign w_inc[gi] = w_grant & reg_write_valid_idix_p1 &
                       (dest_reg_idix_p1 == reg_idx_t'(gi));
    assign w_dec[gi] = dest_reg_write_valid_memwb_p1 &
                       (dest_reg_index_memwb_p1 == reg_idx_t'(gi));

    pending_ctr #(
      .CNT_W(CNT_W)
    ) u_ctr (
      .clk        (clk),
      .rst        (rst),
      .i_inc      (w_inc[gi]),
      .i_dec      (w_dec[gi]),
      .o_cnt      (w_cnt[gi]),
      .o_underflow(w_uflow[gi])
    );

    assign w_pending[gi] = |w_cnt[gi];
  end

  // Hazards read registered counts only, so a same-cycle retire never releases a stall.
  assign w_raw = (src_use_idix_p1[0] & w_pending[rs_idix_p1]) |
                 (src_use_idix_p1[1] & w_pending[rt_idix_p1]) |
                 (src_use_idix_p1[2] & w_pending[rd_idix_p1]);
  assign w_sat = reg_write_valid_idix_p1 & (w_cnt[dest_reg_idix_p1] == CNT_MAX);
  assign w_haz = w_raw | w_sat;

  assign w_grant = issue_valid_idix_p1 & (r_state == RUN) & ~flush_p1 & ~w_haz;
  assign w_stall = issue_valid_idix_p1 & ~w_grant;

  // Next-state logic: a redirect drains every outstanding write before issue resumes.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (flush_p1) begin
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DRAIN: begin
        if ((w_pending == {NUM_REGS{1'b0}}) && !flush_p1) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // Issue state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

`ifdef HAZARD_TIMEOUT_EN
  localparam int TO_W = $clog2(STALL_TIMEOUT + 1);

  logic [TO_W-1:0] r_stall_cnt;
  logic            r_timeout;

  // Consecutive-stall counter; the flag latches on the cycle the count reaches the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= {TO_W{1'b0}};
      r_timeout   <= 1'b0;
    end else if (w_stall) begin
      if (r_stall_cnt != TO_W'(STALL_TIMEOUT)) begin
        r_stall_cnt <= r_stall_cnt + TO_W'(1);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      r_timeout <= r_timeout | (r_stall_cnt == TO_W'(STALL_TIMEOUT - 1));
    end else begin
      r_stall_cnt <= {TO_W{1'b0}};
      r_timeout   <= r_timeout;
    end
  end

  assign hazard_timeout_p1 = r_timeout;
`else
  // Watchdog not built; a negative limit is meaningless so this folds to 0.
  assign hazard_timeout_p1 = (STALL_TIMEOUT < 0);
`endif

  assign issue_grant_p1   = w_grant;
  assign stall_idix_p1    = w_stall;
  assign pending_mask_p1  = w_pending;
  assign underflow_err_p1 = |w_uflow;

endmodule : ix_hazard_ctrl

// File: tb/tb_ix_hazard_ctrl.sv
// Bench for ix_hazard_ctrl: directed scenarios plus random traffic against a
// per-register in-flight count model. Honors HAZARD_TIMEOUT_EN.
module tb_ix_hazard_ctrl;

  localparam int NR     = 8;
  localparam int MAXC   = 3;
  localparam int STL_TO = 4;
`ifdef HAZARD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid = 1'b0;
  logic [2:0]    rs = 3'd0, rt = 3'd0, rd = 3'd0, use_v = 3'd0, dst = 3'd0;
  logic          wv = 1'b0;
  logic [2:0]    ridx = 3'd0;
  logic          rv = 1'b0;
  logic          flush = 1'b0;
  logic          grant, stall, uflow, tout;
  logic [NR-1:0] mask;

  int n_chk = 0;
  int n_err = 0;

  // Model: in-flight writes per register, drain flag, sticky flags, stall run length.
  int m_cnt [NR];
  bit m_drain, m_uflow, m_to;
  int m_run;

  ix_hazard_ctrl #(.NUM_REGS(NR), .CNT_W(2), .STALL_TIMEOUT(STL_TO)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .issue_valid_idix_p1          (valid),
    .rs_idix_p1                   (rs),
    .rt_idix_p1                   (rt),
    .rd_idix_p1                   (rd),
    .src_use_idix_p1              (use_v),
    .dest_reg_idix_p1             (dst),
    .reg_write_valid_idix_p1      (wv),
    .dest_reg_index_memwb_p1      (ridx),
    .dest_reg_write_valid_memwb_p1(rv),
    .flush_p1                     (flush),
    .issue_grant_p1               (grant),
    .stall_idix_p1                (stall),
    .pending_mask_p1              (mask),
    .underflow_err_p1             (uflow),
    .hazard_timeout_p1            (tout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_grant();
    bit blocked;
    blocked = m_drain || flush;
    if (use_v[0] && m_cnt[rs] != 0) blocked = 1'b1;
    if (use_v[1] && m_cnt[rt] != 0) blocked = 1'b1;
    if (use_v[2] && m_cnt[rd] != 0) blocked = 1'b1;
    if (wv && m_cnt[dst] == MAXC) blocked = 1'b1;
    return valid && !blocked;
  endfunction

  function automatic logic [NR-1:0] model_mask();
    logic [NR-1:0] mm;
    for (int i = 0; i < NR; i++) mm[i] = (m_cnt[i] != 0);
    return mm;
  endfunction

  // Compare process: check at every negedge, then advance the model past the coming edge.
  initial begin
    bit g;
    bit all_clear;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        m_drain = 0; m_uflow = 0; m_to = 0; m_run = 0;
      end
      g = model_grant();
      check("grant", grant, g);
      check("stall", stall, valid && !g);
      check("pending_mask", mask, model_mask());
      check("underflow", uflow, m_uflow);
      check("timeout", tout, TO_EN & m_to);
      if (rst) begin
        all_clear = (model_mask() == '0);
        for (int i = 0; i < NR; i++) begin
          bit inc, dec;
          inc = g && wv && (dst == i);
          dec = rv && (ridx == i);
          if (dec && m_cnt[i] == 0) m_uflow = 1;
          if (inc && !dec) m_cnt[i] = m_cnt[i] + 1;
          else if (dec && !inc && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        end
        if (!m_drain) m_drain = flush;
        else m_drain = !(all_clear && !flush);
        if (valid && !g) begin
          m_run++;
          if (m_run >= STL_TO) m_to = 1;
        end else begin
          m_run = 0;
        end
      end
    end
  end

  task automatic apply(input bit v, input logic [2:0] a_rs, input logic [2:0] a_use,
                       input logic [2:0] a_dst, input bit a_wv,
                       input logic [2:0] a_ridx, input bit a_rv, input bit a_fl);
    valid = v; rs = a_rs; rt = 3'd0; rd = 3'd0; use_v = a_use;
    dst = a_dst; wv = a_wv; ridx = a_ridx; rv = a_rv; flush = a_fl;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // RAW stall: write r3, read r3 stalls through the retire cycle, grants after.
    apply(1, 3'd0, 3'b000, 3'd3, 1, 3'd0, 0, 0); check("raw_c0_grant", grant, 1); tick();
    apply(1, 3'd3, 3'b001, 3'd0, 0, 3'd0, 0, 0); check("raw_c1_grant", grant, 0);
    check("raw_c1_mask", mask, 8'h08); check("raw_c1_stall", stall, 1); tick();
    apply(1, 3'd3, 3'b001, 3'd0, 0, 3'd3, 1, 0); check("raw_c2_grant", grant, 0); tick();
    apply(1, 3'd3, 3'b001, 3'd0, 0, 3'd0, 0, 0); check("raw_c3_grant", grant, 1);
    check("raw_c3_mask", mask, 8'h00); tick();

    // Same-cycle increment and decrement on r5 keeps the count at 1.
    apply(1, 3'd0, 3'b000, 3'd5, 1, 3'd0, 0, 0); tick();
    apply(1, 3'd0, 3'b000, 3'd5, 1, 3'd5, 1, 0); check("incdec_grant", grant, 1); tick();
    apply(0, 3'd0, 3'b000, 3'd0, 0, 3'd5, 1, 0); check("incdec_mask5", mask[5], 1);
    check("model_r5", m_cnt[5], 1); tick();
    apply(0, 3'd0, 3'b000, 3'd0, 0, 3'd0, 0, 0); check("incdec_clear", mask, 8'h00); tick();

    // Saturation: three writes to r1 fill its count; a fourth stalls, r2 still issues.
    for (int k = 0; k < 3; k++) begin
      apply(1, 3'd0, 3'b000, 3'd1, 1, 3'd0, 0, 0); check("sat_fill", grant, 1); tick();
    end
    check("model_r1", m_cnt[1], 3);
    apply(1, 3'd0, 3'b000, 3'd1, 1, 3'd0, 0, 0); check("sat_4th", grant, 0); tick();
    apply(1, 3'd0, 3'b000, 3'd2, 1, 3'd0, 0, 0); check("sat_r2", grant, 1); tick();
    for (int k = 0; k < 3; k++) begin
      apply(0, 3'd0, 3'b000, 3'd0, 0, 3'd1, 1, 0); tick();
    end
    apply(0, 3'd0, 3'b000, 3'd0, 0, 3'd2, 1, 0); tick();
    apply(0, 3'd0, 3'b000, 3'd0, 0, 3'd0, 0, 0); check("sat_clear", mask, 8'h00); tick();

    // Flush and drain with r2 and r4 outstanding.
    apply(1, 3'd0, 3'b000, 3'd2, 1, 3'd0, 0, 0); tick();
    apply(1, 3'd0, 3'b000, 3'd4, 1, 3'd0, 0, 0); tick();
    apply(1, 3'd0, 3'b000, 3'd0, 0, 3'd0, 0, 1); check("fl_pulse", grant, 0);
    check("fl_mask", mask, 8'h14); tick();
    apply(1, 3'd0, 3'b000, 3'd0, 0, 3'd0, 0, 0); check("fl_drain0", grant, 0); tick();
    apply(1, 3'd0, 3'b000, 3'd0, 0, 3'd2, 1, 0); check("fl_ret2", grant, 0); tick();
    apply(1, 3'd0, 3'b000, 3'd0, 0, 3'd4, 1, 0); check("fl_ret4", grant, 0); tick();
    apply(1, 3'd0, 3'b000, 3'd0, 0, 3'd0, 0, 0); check("fl_lastdrain", grant, 0);
    check("fl_mask0", mask, 8'h00); tick();
    apply(1, 3'd0, 3'b000, 3'd0, 0, 3'd0, 0, 0); check("fl_run", grant, 1); tick();

    // Underflow: retire r6 with nothing outstanding.
    apply(0, 3'd0, 3'b000, 3'd0, 0, 3'd6, 1, 0); check("uf_before", uflow, 0); tick();
    apply(0, 3'd0, 3'b000, 3'd0, 0, 3'd0, 0, 0); check("uf_set", uflow, 1);
    check("uf_mask", mask, 8'h00); tick();
    check("uf_sticky", uflow, 1);

    // Watchdog: hold a RAW stall on r7 for four cycles.
    apply(1, 3'd0, 3'b000, 3'd7, 1, 3'd0, 0, 0); tick();
    for (int k = 0; k < STL_TO; k++) begin
      apply(1, 3'd7, 3'b001, 3'd0, 0, 3'd0, 0, 0); check("wd_stall", stall, 1); tick();
    end
    apply(1, 3'd7, 3'b001, 3'd0, 0, 3'd7, 1, 0); check("wd_flag", tout, TO_EN); tick();
    apply(1, 3'd7, 3'b001, 3'd0, 0, 3'd0, 0, 0); check("wd_release", grant, 1);
    check("wd_hold", tout, TO_EN); tick();

    // Reset mid-operation clears everything; a later retire is an underflow.
    apply(1, 3'd0, 3'b000, 3'd0, 1, 3'd0, 0, 0); tick();
    apply(0, 3'd0, 3'b000, 3'd0, 0, 3'd0, 0, 0);
    rst = 1'b0; #1;
    check("rst_mask", mask, 8'h00); check("rst_uflow", uflow, 0); check("rst_tout", tout, 0);
    tick();
    rst = 1'b1;
    apply(0, 3'd0, 3'b000, 3'd0, 0, 3'd0, 1, 0); tick();
    apply(0, 3'd0, 3'b000, 3'd0, 0, 3'd0, 0, 0); check("rst_late_retire", uflow, 1); tick();
    rst = 1'b0; tick(); rst = 1'b1;

    // Random traffic; retires only target registers the model holds as outstanding.
    for (int n = 0; n < 3000; n++) begin
      bit          a_rv;
      logic [2:0]  a_ridx;
      int          st;
      a_rv = 0; a_ridx = 3'd0;
      if (n == 1500) begin
        rst = 1'b0; tick(); rst = 1'b1;
      end
      if ($urandom_range(0, 99) < 45) begin
        st = $urandom_range(0, NR - 1);
        for (int k = 0; k < NR; k++) begin
          if (!a_rv && m_cnt[(st + k) % NR] != 0) begin
            a_rv = 1; a_ridx = 3'((st + k) % NR);
          end
        end
      end
      valid = ($urandom_range(0, 3) != 0);
      rs = 3'($urandom_range(0, 7)); rt = 3'($urandom_range(0, 7)); rd = 3'($urandom_range(0, 7));
      use_v = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      dst = 3'($urandom_range(0, 7)); wv = ($urandom_range(0, 1) == 1);
      ridx = a_ridx; rv = a_rv;
      flush = ($urandom_range(0, 39) == 0);
      tick();
    end

    apply(0, 3'd0, 3'b000, 3'd0, 0, 3'd0, 0, 0);
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_ix_hazard_ctrl
